// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/sub result accumulator.
// State encoding, default widths and the sign-extend helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_ACC_W = 8;

    // Sign-extend the low w bits of v to 32 bits (w in 1..32).
    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic [31:0] t;
        t = v << (32 - w);
        return $signed(t) >>> (32 - w);
    endfunction

endpackage

// File: rtl/addsub_accumulator_if.sv
// Beat-in / batch-out handshake bundle for addsub_accumulator.
// slave = accumulator side, master = upstream/downstream side.
interface addsub_accumulator_if #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic             in_cout;
    logic             in_v;
    logic             in_m;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_v;
    logic             out_c;
    logic             out_ovf;

    modport master (
        output in_valid, in_s, in_cout, in_v, in_m, out_ready,
        input  in_ready, out_valid, out_acc, out_v, out_c, out_ovf
    );

    modport slave (
        input  in_valid, in_s, in_cout, in_v, in_m, out_ready,
        output in_ready, out_valid, out_acc, out_v, out_c, out_ovf
    );
endinterface

// File: rtl/acc_sat_adder.sv
// ACC_W signed adder with overflow flag.
// With SATURATE_EN defined the sum clamps to signed max/min on overflow.
module acc_sat_adder #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);
    logic [ACC_W-1:0] raw;

    assign raw   = a_i + b_i;
    assign ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) &&
                   (raw[ACC_W-1] != a_i[ACC_W-1]);

`ifdef SATURATE_EN
    always_comb begin
        sum_o = raw;
        if (ovf_o)
            sum_o = a_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign sum_o = raw;
`endif
endmodule

// File: rtl/addsub_accumulator.sv
// Sums N_OPS sign-extended add/sub beats with sticky V/carry/overflow flags.
// Optional SATURATE_EN clamps the accumulator (see acc_sat_adder).
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_OPS = 4,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    addsub_accumulator_if.slave bus
);
    localparam int CW = $clog2(N_OPS + 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             v_q, v_d;
    logic             c_q, c_d;
    logic             ovf_q, ovf_d;

    logic             in_ready;
    logic             accept;
    logic             carry;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;

    assign in_ready = !rst && !clear && (state_q != HOLD);
    assign accept   = bus.in_valid && in_ready;
    // Subtract mode reports borrow as Cout=0.
    assign carry    = bus.in_m ^ bus.in_cout;
    assign ext      = ACC_W'(sext(32'(bus.in_s), WIDTH));

    acc_sat_adder #(.ACC_W(ACC_W)) u_add (
        .a_i  (acc_q),
        .b_i  (ext),
        .sum_o(sum),
        .ovf_o(add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = ext;
                    cnt_d   = CW'(1);
                    v_d     = bus.in_v;
                    c_d     = carry;
                    ovf_d   = 1'b0;
                    state_d = (N_OPS == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CW'(1);
                    v_d   = v_q | bus.in_v;
                    c_d   = c_q | carry;
                    ovf_d = ovf_q | add_ovf;
                    if (cnt_q == CW'(N_OPS - 1))
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            v_d     = 1'b0;
            c_d     = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_acc   = acc_q;
    assign bus.out_v     = v_q;
    assign bus.out_c     = c_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_addsub_accumulator.sv
// Bench for addsub_accumulator: 8-bit and 5-bit accumulators fed the same
// beats, checked every cycle against a batch-level arithmetic model.
module tb_addsub_accumulator;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_s = '0;
    logic       in_cout = 1'b0;
    logic       in_v = 1'b0;
    logic       in_m = 1'b0;
    logic       out_ready = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    addsub_accumulator_if #(.WIDTH(4), .ACC_W(8)) bus8 ();
    addsub_accumulator_if #(.WIDTH(4), .ACC_W(5)) bus5 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_s      = in_s;
    assign bus8.in_cout   = in_cout;
    assign bus8.in_v      = in_v;
    assign bus8.in_m      = in_m;
    assign bus8.out_ready = out_ready;
    assign bus5.in_valid  = in_valid;
    assign bus5.in_s      = in_s;
    assign bus5.in_cout   = in_cout;
    assign bus5.in_v      = in_v;
    assign bus5.in_m      = in_m;
    assign bus5.out_ready = out_ready;

    addsub_accumulator #(.WIDTH(4), .N_OPS(N), .ACC_W(8)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .bus  (bus8)
    );

    addsub_accumulator #(.WIDTH(4), .N_OPS(N), .ACC_W(5)) dut5 (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .bus  (bus5)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the beats of the current batch as signed integers.
    int s_q[$];
    bit m_v, m_c, m_live;

    function automatic void fold(input int w, output int acc, output bit ovf);
        int mx;
        int mn;
        int t;
        mx  = (1 << (w - 1)) - 1;
        mn  = -(1 << (w - 1));
        ovf = 1'b0;
        acc = s_q[0];
        for (int i = 1; i < s_q.size(); i++) begin
            t = acc + s_q[i];
            if (t > mx || t < mn) begin
                ovf = 1'b1;
`ifdef SATURATE_EN
                t = (t > mx) ? mx : mn;
`else
                t = (((t - mn) % (1 << w)) + (1 << w)) % (1 << w) + mn;
`endif
            end
            acc = t;
        end
    endfunction

    initial forever begin
        int  a8, a5, sv;
        bit  o8, o5, hold;
        @(negedge clk);
        hold = (s_q.size() == N);
        if (m_live) begin
            chk("in_ready8", longint'(bus8.in_ready), longint'(!rst && !clear && !hold));
            chk("in_ready5", longint'(bus5.in_ready), longint'(!rst && !clear && !hold));
            chk("out_valid8", longint'(bus8.out_valid), longint'(hold));
            chk("out_valid5", longint'(bus5.out_valid), longint'(hold));
            if (hold) begin
                fold(8, a8, o8);
                fold(5, a5, o5);
                chk("acc8", longint'(bus8.out_acc), longint'(a8 & 8'hFF));
                chk("acc5", longint'(bus5.out_acc), longint'(a5 & 5'h1F));
                chk("ovf8", longint'(bus8.out_ovf), longint'(o8));
                chk("ovf5", longint'(bus5.out_ovf), longint'(o5));
                chk("v8", longint'(bus8.out_v), longint'(m_v));
                chk("c8", longint'(bus8.out_c), longint'(m_c));
                chk("c5", longint'(bus5.out_c), longint'(m_c));
            end
        end
        // Advance the model by the upcoming rising edge.
        if (rst || clear) begin
            s_q.delete();
            m_v = 1'b0;
            m_c = 1'b0;
            if (rst) m_live = 1'b1;
        end else if (hold) begin
            if (out_ready) s_q.delete();
        end else if (in_valid) begin
            if (s_q.size() == 0) begin
                m_v = 1'b0;
                m_c = 1'b0;
            end
            sv = $signed(in_s);
            s_q.push_back(sv);
            m_v = m_v | in_v;
            m_c = m_c | (in_m ? !in_cout : in_cout);
        end
    end

    task automatic send(input logic [3:0] s, input bit co, input bit v, input bit m);
        bit r;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_s     = s;
        in_cout  = co;
        in_v     = v;
        in_m     = m;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            r = bus8.in_ready;
            @(posedge clk);
            #1;
            done = r;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic result(input string name, input logic [7:0] acc,
                          input bit v, input bit c, input bit ovf, input int hold_cycles);
        @(negedge clk);
        chk({name, "_latency"}, longint'(bus8.out_valid), 1);
        for (int k = 0; k < 10 && !bus8.out_valid; k++) @(negedge clk);
        chk({name, "_acc"}, longint'(bus8.out_acc), longint'(acc));
        chk({name, "_v"}, longint'(bus8.out_v), longint'(v));
        chk({name, "_c"}, longint'(bus8.out_c), longint'(c));
        chk({name, "_ovf"}, longint'(bus8.out_ovf), longint'(ovf));
        for (int k = 0; k < hold_cycles; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_s     = 4'h7;
            @(negedge clk);
            chk({name, "_hold_acc"}, longint'(bus8.out_acc), longint'(acc));
            chk({name, "_hold_rdy"}, longint'(bus8.in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        send(4'b0011, 0, 0, 0);
        send(4'b0101, 0, 0, 0);
        send(4'b1110, 0, 0, 0);
        send(4'b0001, 0, 0, 0);
        result("t1", 8'h07, 0, 0, 0, 0);

        send(4'b1000, 0, 1, 0);
        repeat (3) send(4'b0001, 0, 0, 0);
        result("t2", 8'hFB, 1, 0, 0, 0);

        send(4'b1110, 0, 0, 1);
        repeat (3) send(4'b0001, 0, 0, 0);
        result("t3a", 8'h01, 0, 1, 0, 0);
        repeat (4) send(4'b0001, 0, 0, 0);
        result("t3b", 8'h04, 0, 0, 0, 0);

        repeat (4) send(4'b0010, 0, 0, 0);
        result("t4", 8'h08, 0, 0, 0, 3);

        send(4'b0011, 0, 0, 0);
        send(4'b0011, 0, 0, 0);
        in_valid = 1'b1;
        in_s     = 4'b0111;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        repeat (4) send(4'b0001, 0, 0, 0);
        result("t5", 8'h04, 0, 0, 0, 0);

        repeat (4) send(4'b0111, 0, 0, 0);
        @(negedge clk);
`ifdef SATURATE_EN
        chk("t6_acc5", longint'(bus5.out_acc), longint'(5'b01111));
`else
        chk("t6_acc5", longint'(bus5.out_acc), longint'(5'b11100));
`endif
        chk("t6_ovf5", longint'(bus5.out_ovf), 1);
        result("t6", 8'h1C, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_s      = 4'($urandom);
            in_cout   = 1'($urandom);
            in_v      = ($urandom_range(0, 7) == 0);
            in_m      = 1'($urandom);
            out_ready = 1'($urandom);
            clear     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) == 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear     = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
